// File: rtl/ahb_ap_pkg.sv
// ahb_ap_pkg: shared constants and types for the AHB access port (JTAG side and AHB side).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Optional feature macro AHB_RESP_STICKY_EN widens the response DR by one sticky_empty bit.
package ahb_ap_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;
`ifdef AHB_RESP_STICKY_EN
  localparam int RESP_W = DATA_W + 3;
`else
  localparam int RESP_W = DATA_W + 2;
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURED = 2'd1,
    SHIFTING = 2'd2
  } resp_state_t;

  // One FIFO entry as written by the AHB-side engine; the FIFO stores it as {err, data}.
  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] data;
  } ahb_resp_t;

endpackage

// File: rtl/ahb_resp_reg_if.sv
// ahb_resp_reg_if: bundle of the response-DR signals (TAP strobes, serial pins, FIFO read side).
// Latency: n/a (wires only).
// Backpressure: FIFO pops are driven by the register through rinc; the FIFO never stalls it.
// Ports: see modport AHB_RESP_REG, which is the register's own view of the bundle.
interface ahb_resp_reg_if #(
  parameter int DATA_W = ahb_ap_pkg::DATA_W
);
  logic              TCK;
  logic              tlr_reset;
  logic              resp_select;
  logic              dr_capture;
  logic              dr_shift;
  logic              dr_update;
  logic              TDI;
  logic              TDO;
  logic [DATA_W:0]   rdata;
  logic              rempty;
  logic              rinc;
  logic              resp_pending;

  modport AHB_RESP_REG (
    input  TCK, tlr_reset, resp_select, dr_capture, dr_shift, dr_update, TDI,
    input  rdata, rempty,
    output TDO, rinc, resp_pending
  );
endinterface

// File: rtl/ahb_resp_reg.sv
// ahb_resp_reg: JTAG read-back DR that scans out the head of the AHB response FIFO.
// Latency: head captured in Capture-DR, streamed LSB first; pop strobe is combinational in Update-DR.
// Backpressure: FIFO is popped only after a complete scan, so aborted/short/over scans lose nothing.
// Ports:
//   TCK, tlr_reset                 - test clock, synchronous active-high reset (Test-Logic-Reset)
//   resp_select                    - IR currently selects this DR
//   dr_capture/dr_shift/dr_update  - TAP state strobes
//   TDI / TDO                      - serial in / out (TDO = shreg[0])
//   rdata, rempty, rinc            - FWFT FIFO head {err, data}, empty flag, pop strobe
//   resp_pending                   - registered ~rempty for the JTAG status word
// Optional feature: define AHB_RESP_STICKY_EN to add a sticky_empty bit at the DR MSB.
module ahb_resp_reg #(
  parameter int DATA_W = ahb_ap_pkg::DATA_W,
  parameter int CNT_W  = ahb_ap_pkg::CNT_W
) (
  input  logic            TCK,
  input  logic            tlr_reset,
  input  logic            resp_select,
  input  logic            dr_capture,
  input  logic            dr_shift,
  input  logic            dr_update,
  input  logic            TDI,
  output logic            TDO,
  input  logic [DATA_W:0] rdata,
  input  logic            rempty,
  output logic            rinc,
  output logic            resp_pending
);
  import ahb_ap_pkg::*;

`ifdef AHB_RESP_STICKY_EN
  localparam int RESP_W = DATA_W + 3;
`else
  localparam int RESP_W = DATA_W + 2;
`endif
  localparam logic [CNT_W-1:0] RESP_CNT = CNT_W'(RESP_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  resp_state_t       state_q, state_d;
  logic [RESP_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              loaded_valid_q, loaded_valid_d;
  logic              resp_pending_q;
  logic [RESP_W-1:0] cap_word;
  logic              full_update;

`ifdef AHB_RESP_STICKY_EN
  logic sticky_q, sticky_d;
`endif

  // A full-length update is the only event that completes a response.
  assign full_update = resp_select & dr_update & (count_q == RESP_CNT);

  // Pop only if the scanned word held a real entry; reset suppresses any pop mid-scan.
  assign rinc         = full_update & loaded_valid_q & ~tlr_reset;
  assign TDO          = shreg_q[0];
  assign resp_pending = resp_pending_q;

  // Capture image: an empty FIFO yields valid=err=data=0 whatever rdata shows.
  always_comb begin
    cap_word = '0;
    if (!rempty) begin
      cap_word[0]          = 1'b1;
      cap_word[1]          = rdata[DATA_W];
      cap_word[DATA_W+1:2] = rdata[DATA_W-1:0];
    end
`ifdef AHB_RESP_STICKY_EN
    cap_word[RESP_W-1] = sticky_q;
`endif
  end

  // Strobe priority: update > capture > shift. Deselect during capture/shift parks the FSM.
  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    count_d        = count_q;
    loaded_valid_d = loaded_valid_q;

    if (dr_update) begin
      state_d        = IDLE;
      count_d        = '0;
      loaded_valid_d = 1'b0;
    end else if (dr_capture) begin
      if (resp_select) begin
        state_d        = CAPTURED;
        shreg_d        = cap_word;
        count_d        = '0;
        loaded_valid_d = ~rempty;
      end else begin
        state_d = IDLE;
      end
    end else if (dr_shift) begin
      if (resp_select) begin
        if (state_q != IDLE) begin
          state_d = SHIFTING;
        end
        shreg_d = {TDI, shreg_q[RESP_W-1:1]};
        // Saturate so a very long over-scan can never wrap back to RESP_W.
        if (count_q != CNT_MAX) begin
          count_d = count_q + CNT_W'(1);
        end
      end else begin
        state_d = IDLE;
      end
    end
  end

`ifdef AHB_RESP_STICKY_EN
  // Set is not gated by update priority so that a set always wins over a clear.
  always_comb begin
    sticky_d = sticky_q;
    if (dr_capture & resp_select & rempty) begin
      sticky_d = 1'b1;
    end else if (full_update) begin
      sticky_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge TCK) begin
    if (tlr_reset) begin
      state_q        <= IDLE;
      shreg_q        <= '0;
      count_q        <= '0;
      loaded_valid_q <= 1'b0;
      resp_pending_q <= 1'b0;
`ifdef AHB_RESP_STICKY_EN
      sticky_q       <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      count_q        <= count_d;
      loaded_valid_q <= loaded_valid_d;
      resp_pending_q <= ~rempty;
`ifdef AHB_RESP_STICKY_EN
      sticky_q       <= sticky_d;
`endif
    end
  end

endmodule

// File: tb/tb_ahb_resp_reg.sv
// tb_ahb_resp_reg: directed plus randomized scans of ahb_resp_reg against a queue-based FIFO model.
// Latency: one TCK per TAP step; outputs sampled 1 time unit after the rising edge.
// Backpressure: the bench FIFO pops whenever the DUT raises rinc; expected pops come from the model.
module tb_ahb_resp_reg;
  import ahb_ap_pkg::*;

  ahb_resp_reg_if #(.DATA_W(DATA_W)) bus ();

  ahb_resp_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .TCK          (bus.TCK),
    .tlr_reset    (bus.tlr_reset),
    .resp_select  (bus.resp_select),
    .dr_capture   (bus.dr_capture),
    .dr_shift     (bus.dr_shift),
    .dr_update    (bus.dr_update),
    .TDI          (bus.TDI),
    .TDO          (bus.TDO),
    .rdata        (bus.rdata),
    .rempty       (bus.rempty),
    .rinc         (bus.rinc),
    .resp_pending (bus.resp_pending)
  );

  initial begin
    bus.TCK = 1'b0;
    forever #5 bus.TCK = ~bus.TCK;
  end

  int              tests = 0;
  int              fails = 0;
  logic [DATA_W:0] fifo_q[$];
  logic            sticky_m = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    bus.rempty = (fifo_q.size() == 0);
    bus.rdata  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  task automatic push(input logic err, input logic [DATA_W-1:0] data);
    fifo_q.push_back({err, data});
    refresh();
  endtask

  task automatic strobes(input logic cap, input logic sh, input logic upd);
    bus.dr_capture = cap;
    bus.dr_shift   = sh;
    bus.dr_update  = upd;
  endtask

  // One TCK; resp_pending must show the pre-edge ~rempty (zero while in reset).
  task automatic tick();
    logic pend_exp;
    logic popped;
    pend_exp = !bus.rempty && !bus.tlr_reset;
    popped   = bus.rinc;
    @(posedge bus.TCK);
    #1;
    if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
    refresh();
    check("resp_pending", {63'd0, bus.resp_pending}, {63'd0, pend_exp});
  endtask

  // Capture, nshift shifts (optionally reset before shift rst_at), update.
  task automatic scan(input int nshift, input int rst_at);
    logic [RESP_W-1:0] exp_w;
    logic              stream[$];
    logic              exp_valid;
    logic              aborted;
    logic              exp_rinc;
    logic              t;
    int                size_before;

    exp_valid = (fifo_q.size() != 0);
    exp_w     = '0;
    if (exp_valid) exp_w[DATA_W+1:0] = {fifo_q[0][DATA_W-1:0], fifo_q[0][DATA_W], 1'b1};
`ifdef AHB_RESP_STICKY_EN
    exp_w[RESP_W-1] = sticky_m;
`endif
    if (!exp_valid) sticky_m = 1'b1;
    for (int i = 0; i < RESP_W; i++) stream.push_back(exp_w[i]);

    aborted = 1'b0;
    bus.resp_select = 1'b1;
    strobes(1'b1, 1'b0, 1'b0);
    tick();

    for (int i = 0; i < nshift; i++) begin
      if (i == rst_at) begin
        bus.tlr_reset = 1'b1;
        strobes(1'b0, 1'b1, 1'b0);
        #1;
        check("rinc_in_reset", {63'd0, bus.rinc}, 64'd0);
        tick();
        bus.tlr_reset = 1'b0;
        check("tdo_after_reset", {63'd0, bus.TDO}, 64'd0);
        aborted  = 1'b1;
        sticky_m = 1'b0;
        break;
      end
      check("tdo_bit", {63'd0, bus.TDO}, {63'd0, stream[i]});
      t = 1'($urandom_range(0, 1));
      bus.TDI = t;
      stream.push_back(t);
      strobes(1'b0, 1'b1, 1'b0);
      tick();
    end

    strobes(1'b0, 1'b0, 1'b1);
    exp_rinc = !aborted && (nshift == RESP_W) && exp_valid;
    #1;
    check("rinc_at_update", {63'd0, bus.rinc}, {63'd0, exp_rinc});
    size_before = fifo_q.size();
    tick();
    if (!aborted && nshift == RESP_W) sticky_m = 1'b0;
    check("fifo_depth", 64'(fifo_q.size()), 64'(size_before - int'(exp_rinc)));
    strobes(1'b0, 1'b0, 1'b0);
    #1;
    check("rinc_one_cycle", {63'd0, bus.rinc}, 64'd0);
  endtask

  initial begin
    int n;
    bus.tlr_reset   = 1'b1;
    bus.resp_select = 1'b0;
    bus.TDI         = 1'b0;
    strobes(1'b0, 1'b0, 1'b0);
    refresh();
    tick();
    tick();
    check("reset_tdo", {63'd0, bus.TDO}, 64'd0);
    check("reset_rinc", {63'd0, bus.rinc}, 64'd0);
    check("reset_pending", {63'd0, bus.resp_pending}, 64'd0);
    bus.tlr_reset = 1'b0;
    tick();

    // Full scan pops DEADBEEF.
    push(1'b0, 32'hDEADBEEF);
    tick();
    scan(RESP_W, -1);
    // Short scan keeps the head; recapture re-presents it.
    push(1'b0, 32'hDEADBEEF);
    scan(20, -1);
    scan(RESP_W, -1);
    // Empty FIFO: all-zero word, no pop.
    scan(RESP_W, -1);
    // Error response with zero data.
    push(1'b1, 32'h0);
    scan(RESP_W, -1);
    // Reset mid-scan preserves the head; next full scan pops it.
    push(1'b0, DATA_W'($urandom));
    scan(RESP_W, 10);
    check("head_kept_after_reset", 64'(fifo_q.size()), 64'd1);
    scan(RESP_W, -1);
    // Over-scan, including one long enough to saturate the counter.
    push(1'b0, DATA_W'($urandom));
    scan(RESP_W + 5, -1);
    scan(70, -1);
    scan(RESP_W, -1);
    // Sticky-empty sequence (bit only present with the optional feature).
    scan(12, -1);
    push(1'b0, 32'h12345678);
    scan(RESP_W, -1);
    scan(RESP_W, -1);

    // Randomized traffic.
    for (int it = 0; it < 24; it++) begin
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) push(1'($urandom_range(0, 1)), DATA_W'($urandom));
      case ($urandom_range(0, 3))
        0:       scan($urandom_range(1, RESP_W - 1), -1);
        1:       scan($urandom_range(RESP_W + 1, RESP_W + 8), -1);
        default: scan(RESP_W, -1);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
